l2_tag_directory: RTL and testbench
===================================

Name: l2_tag_directory

Overview:
- Parametrised N-way set-associative tag/state directory for the L2 cache.
- Successor to the fixed single-lookup check-cache/set-MESI/LRU functions: one clocked block with a request/response interface, true-LRU age tracking and victim selection.
- Supports four ops: LOOKUP, FILL (allocate with eviction report), SET_MESI and INVALIDATE.
- Includes a post-reset init sweep. Sits between the L2 request arbiter and the data-array/snoop logic.

Parameters:
- WAYS, 8: associativity; power of 2, at least 2. Derived WAY_BITS = log2(WAYS).
- INDEX_BITS, 6: set index width. SETS = 2^INDEX_BITS.
- TAG_BITS, 12: stored tag width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_op  in  2  00 LOOKUP, 01 FILL, 10 SET_MESI, 11 INVALIDATE.
- req_index  in  INDEX_BITS  set index.
- req_tag  in  TAG_BITS  tag.
- req_mesi  in  2  new state for FILL/SET_MESI. Encoding: I=00, S=01, E=10, M=11.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_hit  out  1  tag matched a non-I way.
- rsp_way  out  WAY_BITS  hit way, or victim/allocated way on miss.
- rsp_mesi  out  2  state of rsp_way before this op.
- rsp_victim_tag  out  TAG_BITS  evicted tag (FILL miss only, else 0).
- rsp_victim_mesi  out  2  evicted state (FILL miss only, else I).
- init_done  out  1  init sweep complete.

Behaviour:
- Reset: all outputs 0 immediately (req_ready=0, rsp_valid=0, init_done=0); FSM enters INIT with sweep counter 0.
- Reset asserted mid-operation aborts any response and restarts INIT. No earlier contents survive.
- FSM INIT: each edge after rst deasserts writes one set: all ways mesi=I, tag=0, age[w]=w. Counter increments by one per set.
- INIT -> READY on the edge that writes set SETS-1. req_ready and init_done go high exactly SETS edges after rst deassertion. INIT is never re-entered except by reset.
- READY: req_ready=1 every cycle; no backpressure on responses.
- A request is accepted on an edge where req_valid and req_ready are both 1.
- Array update and registered response happen on that same edge. rsp_valid is high for the following cycle, so latency is 1.
- Back-to-back requests are allowed every cycle. A request sees all updates from earlier accepted requests, including same-index requests on consecutive cycles.
- Hit detection: way w hits if mesi[w] != I and tag[w] == req_tag. At most one way may hit (invariant maintained by FILL).
- Victim selection: lowest-numbered way with mesi=I; if none, the way with age = WAYS-1.
- Touch(w): every way with age < age[w] increments its age; age[w] becomes 0. Ages in a set always form a permutation of 0..WAYS-1.
- LOOKUP:
  - Hit: rsp_hit=1, rsp_way=hit way, rsp_mesi=its state, touch.
  - Miss: rsp_hit=0, rsp_way=victim, rsp_mesi=victim state, no state change.
- FILL:
  - req_mesi=I: no state change; rsp_hit=0, rsp_way=victim.
  - Hit: overwrite mesi with req_mesi, touch, rsp_hit=1.
  - Miss: rsp_victim_tag/rsp_victim_mesi = old victim contents (victim_mesi=I when an invalid way was used). Write req_tag and req_mesi to the victim way, touch, rsp_hit=0, rsp_way=victim.
- SET_MESI:
  - Hit: mesi := req_mesi (I permitted), ages unchanged, rsp_mesi = prior state.
  - Miss: no change.
- INVALIDATE:
  - Hit: mesi := I, ages unchanged, rsp_mesi = prior state (caller uses M for writeback).
  - Miss: no change.
- req_valid during INIT is ignored: not accepted, no response.

Test Plan:
- Reset -> release: req_ready/init_done stay 0 for exactly 64 edges, then 1. LOOKUP idx 0 tag 12'h111 -> rsp_hit=0, rsp_way=0, rsp_mesi=I.
- FILL idx 0 tags 12'h0AA (S), 12'h0BB (S), 12'h111 (E) -> ways 0,1,2. LOOKUP 12'h111 -> rsp_hit=1, rsp_way=2, rsp_mesi=E.
- FILL idx 5 tags 12'h100..12'h107 (S) into ways 0..7, LOOKUP 12'h100, then FILL 12'h108 (E) -> rsp_way=1, rsp_victim_tag=12'h101, rsp_victim_mesi=S. LOOKUP 12'h101 -> miss.
- SET_MESI idx 5 tag 12'h102 to M -> rsp_mesi=S. INVALIDATE 12'h102 -> rsp_mesi=M. LOOKUP 12'h102 -> miss, rsp_way=2 (lowest invalid).
- FILL then LOOKUP same idx/tag on consecutive cycles -> second response rsp_hit=1 with the filled way.
- Assert rst while rsp_valid=1 -> all outputs 0 same cycle. After the 64-edge re-init, every prior tag misses.

Source files
------------

// File: rtl/l2_tag_directory.sv
// l2_tag_directory: N-way set-associative tag/MESI directory with true-LRU ages and post-reset init sweep
module l2_tag_directory #(
    parameter int WAYS = 8,
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS = 12,
    localparam int WAY_BITS = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [INDEX_BITS-1:0] req_index,
    input  logic [TAG_BITS-1:0]   req_tag,
    input  logic [1:0]            req_mesi,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [WAY_BITS-1:0]   rsp_way,
    output logic [1:0]            rsp_mesi,
    output logic [TAG_BITS-1:0]   rsp_victim_tag,
    output logic [1:0]            rsp_victim_mesi,
    output logic                  init_done
);
    localparam int SETS = 1 << INDEX_BITS;
    localparam logic [0:0] INIT = 1'b0, READY = 1'b1;
    logic [0:0] state;
    logic [INDEX_BITS-1:0] cnt;
    logic [TAG_BITS-1:0] tags [SETS][WAYS];
    logic [1:0] mesi [SETS][WAYS];
    logic [WAY_BITS-1:0] age [SETS][WAYS];
    logic accept, hit, has_inv, fill, fill_i, touch, wr_mesi, evict;
    logic [WAY_BITS-1:0] hway, iway, oway, vway, way;
    logic [1:0] new_mesi;
    assign req_ready = state == READY;
    assign init_done = state == READY;
    assign accept = req_valid && req_ready;
    // Descending scan leaves the lowest-numbered invalid way in iway
    always_comb begin
        hit = 1'b0;
        has_inv = 1'b0;
        hway = '0;
        iway = '0;
        oway = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mesi[req_index][w] != 2'b00 && tags[req_index][w] == req_tag) begin
                hit = 1'b1;
                hway = WAY_BITS'(w);
            end
            if (mesi[req_index][w] == 2'b00) begin
                has_inv = 1'b1;
                iway = WAY_BITS'(w);
            end
            if (age[req_index][w] == WAY_BITS'(WAYS - 1)) oway = WAY_BITS'(w);
        end
    end
    assign vway = has_inv ? iway : oway;
    assign fill = req_op == 2'b01;
    assign fill_i = fill && req_mesi == 2'b00;
    assign way = hit && !fill_i ? hway : vway;
    assign touch = (req_op == 2'b00 && hit) || (fill && !fill_i);
    assign wr_mesi = fill ? !fill_i : req_op[1] && hit;
    assign new_mesi = req_op == 2'b11 ? 2'b00 : req_mesi;
    assign evict = fill && !fill_i && !hit;
    // Storage arrays are cleared by the INIT sweep rather than by reset
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            for (int w = 0; w < WAYS; w++) begin
                mesi[cnt][w] <= 2'b00;
                tags[cnt][w] <= '0;
                age[cnt][w] <= WAY_BITS'(w);
            end
        end else if (accept) begin
            if (wr_mesi) mesi[req_index][way] <= new_mesi;
            if (evict) tags[req_index][way] <= req_tag;
            if (touch)
                for (int w = 0; w < WAYS; w++)
                    age[req_index][w] <= WAY_BITS'(w) == way ? '0 :
                        age[req_index][w] < age[req_index][way] ? age[req_index][w] + 1'b1 : age[req_index][w];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt <= '0;
            rsp_valid <= 1'b0;
            rsp_hit <= 1'b0;
            rsp_way <= '0;
            rsp_mesi <= 2'b00;
            rsp_victim_tag <= '0;
            rsp_victim_mesi <= 2'b00;
        end else begin
            rsp_valid <= accept;
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
                if (cnt == INDEX_BITS'(SETS - 1)) state <= READY;
            end
            if (accept) begin
                rsp_hit <= hit && !fill_i;
                rsp_way <= way;
                rsp_mesi <= mesi[req_index][way];
                rsp_victim_tag <= evict ? tags[req_index][way] : '0;
                rsp_victim_mesi <= evict ? mesi[req_index][way] : 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_l2_tag_directory.sv
// tb_l2_tag_directory: randomized scoreboard bench against a recency-list reference model
module tb_l2_tag_directory;
    logic clk = 1'b0, rst, req_valid, req_ready, rsp_valid, rsp_hit, init_done;
    logic [1:0] req_op, req_mesi, rsp_mesi, rsp_victim_mesi;
    logic [5:0] req_index;
    logic [11:0] req_tag, rsp_victim_tag;
    logic [2:0] rsp_way;
    int n_chk = 0, n_fail = 0;
    typedef struct packed {
        logic hit;
        logic [2:0] way;
        logic [1:0] mesi;
        logic [11:0] vt;
        logic [1:0] vm;
    } exp_t;
    exp_t q[$];
    logic [11:0] mt [64][8];
    logic [1:0] mm [64][8];
    int ord [64][8];
    always #5 clk = ~clk;
    l2_tag_directory dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_index(req_index), .req_tag(req_tag), .req_mesi(req_mesi),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_mesi(rsp_mesi),
        .rsp_victim_tag(rsp_victim_tag), .rsp_victim_mesi(rsp_victim_mesi), .init_done(init_done)
    );
    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction
    // ord[s] lists ways most-recent first; its last entry is the LRU way
    task automatic model_reset();
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 8; w++) begin
                mt[s][w] = '0;
                mm[s][w] = 2'b00;
                ord[s][w] = w;
            end
    endtask
    task automatic touch(int s, int w);
        int p = 0;
        for (int i = 0; i < 8; i++) if (ord[s][i] == w) p = i;
        for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
        ord[s][0] = w;
    endtask
    task automatic send(logic [1:0] op, int s, logic [11:0] tag, logic [1:0] m);
        int h = -1, v = -1;
        exp_t e = '0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_index = 6'(s);
        req_tag = tag;
        req_mesi = m;
        for (int w = 0; w < 8; w++) if (mm[s][w] != 2'b00 && mt[s][w] == tag) h = w;
        for (int w = 7; w >= 0; w--) if (mm[s][w] == 2'b00) v = w;
        if (v < 0) v = ord[s][7];
        if (h >= 0 && !(op == 2'b01 && m == 2'b00)) begin
            e.hit = 1'b1;
            e.way = 3'(h);
            e.mesi = mm[s][h];
            if (op == 2'b00) touch(s, h);
            if (op == 2'b01) begin mm[s][h] = m; touch(s, h); end
            if (op == 2'b10) mm[s][h] = m;
            if (op == 2'b11) mm[s][h] = 2'b00;
        end else begin
            e.way = 3'(v);
            e.mesi = mm[s][v];
            if (op == 2'b01 && m != 2'b00) begin
                e.vt = mt[s][v];
                e.vm = mm[s][v];
                mt[s][v] = tag;
                mm[s][v] = m;
                touch(s, v);
            end
        end
        q.push_back(e);
    endtask
    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask
    task automatic do_init();
        int n = 0;
        @(negedge clk);
        rst = 1'b0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (init_done) break;
            chk("ready_during_init", {31'b0, req_ready}, 0);
            req_valid = 1'($urandom);
        end
        req_valid = 1'b0;
        chk("init_edges", n, 64);
        chk("ready_after_init", {31'b0, req_ready}, 1);
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (q.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("rsp_hit", {31'b0, rsp_hit}, {31'b0, e.hit});
                    chk("rsp_way", {29'b0, rsp_way}, {29'b0, e.way});
                    chk("rsp_mesi", {30'b0, rsp_mesi}, {30'b0, e.mesi});
                    chk("rsp_victim_tag", {20'b0, rsp_victim_tag}, {20'b0, e.vt});
                    chk("rsp_victim_mesi", {30'b0, rsp_victim_mesi}, {30'b0, e.vm});
                end
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 2'b00;
        req_index = '0;
        req_tag = '0;
        req_mesi = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'b0, req_ready}, 0);
        chk("reset_init_done", {31'b0, init_done}, 0);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 0);
        do_init();
        send(2'b00, 0, 12'h111, 2'b00);
        send(2'b01, 0, 12'h0AA, 2'b01);
        send(2'b01, 0, 12'h0BB, 2'b01);
        send(2'b01, 0, 12'h111, 2'b10);
        send(2'b00, 0, 12'h111, 2'b00);
        for (int i = 0; i < 8; i++) send(2'b01, 5, 12'h100 + 12'(i), 2'b01);
        send(2'b00, 5, 12'h100, 2'b00);
        send(2'b01, 5, 12'h108, 2'b10);
        send(2'b00, 5, 12'h101, 2'b00);
        send(2'b10, 5, 12'h102, 2'b11);
        send(2'b11, 5, 12'h102, 2'b00);
        send(2'b00, 5, 12'h102, 2'b00);
        send(2'b01, 9, 12'h3C3, 2'b11);
        send(2'b00, 9, 12'h3C3, 2'b00);
        idle();
        for (int i = 0; i < 800; i++)
            if ($urandom_range(7) == 0) idle();
            else send(2'($urandom), $urandom_range(3), 12'($urandom_range(15)), 2'($urandom));
        send(2'b00, 0, 12'h111, 2'b00);
        idle();
        #1;
        chk("pre_reset_rsp_valid", {31'b0, rsp_valid}, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("abort_ready", {31'b0, req_ready}, 0);
        chk("abort_init_done", {31'b0, init_done}, 0);
        chk("abort_rsp_fields", {rsp_hit, rsp_way, rsp_mesi, rsp_victim_tag, rsp_victim_mesi}, 0);
        repeat (2) @(posedge clk);
        model_reset();
        do_init();
        send(2'b00, 0, 12'h111, 2'b00);
        send(2'b00, 0, 12'h0AA, 2'b00);
        send(2'b00, 5, 12'h108, 2'b00);
        send(2'b00, 5, 12'h100, 2'b00);
        send(2'b00, 9, 12'h3C3, 2'b00);
        for (int t = 0; t < 16; t++) send(2'b00, t % 4, 12'(t), 2'b00);
        idle();
        repeat (3) @(negedge clk);
        chk("drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
